config_cmd_decoder: RTL

CONFIG_CMD_DECODER -- requirements
Module: config_cmd_decoder

---
 rtl/config_cmd_decoder_pkg.sv | 31 +++
 rtl/config_cmd_decoder_sat_cnt16.sv | 17 +
 rtl/config_cmd_decoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/config_cmd_decoder_pkg.sv
// rtl/config_cmd_decoder_pkg.sv - shared constants, state encoding and helpers for the config command decoder
package config_cmd_decoder_pkg;

    localparam logic [7:0]  HDR0_DEFAULT    = 8'hEB;
    localparam logic [7:0]  HDR1_DEFAULT    = 8'h90;
    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd1000;

    localparam logic [7:0]  ADDR_MIN = 8'h02;
    localparam logic [7:0]  ADDR_MAX = 8'h15;

    localparam logic [7:0]  WR_ADDR_RST = 8'h00;
    localparam logic [15:0] DATA_RST    = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_ADDR = 3'd2,
        ST_DHI  = 3'd3,
        ST_DLO  = 3'd4,
        ST_CKS  = 3'd5
    } state_t;

    function automatic logic [7:0] cks_of(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo);
        return a + hi + lo;
    endfunction

    function automatic logic addr_in_range(input logic [7:0] a);
        return (a >= ADDR_MIN) && (a <= ADDR_MAX);
    endfunction

endpackage

// File: rtl/config_cmd_decoder_sat_cnt16.sv
// rtl/config_cmd_decoder_sat_cnt16.sv - 16-bit saturating incrementer with synchronous clear
module sat_cnt16 (
    input  logic        clk_in,
    input  logic        clr_in,
    input  logic        inc_in,
    output logic [15:0] count_out
);

    always_ff @(posedge clk_in) begin
        if (clr_in) begin
            count_out <= 16'h0000;
        end else if (inc_in && (count_out != 16'hFFFF)) begin
            count_out <= count_out + 16'd1;
        end
    end

endmodule

// File: rtl/config_cmd_decoder.sv
// rtl/config_cmd_decoder.sv - byte-stream frame parser issuing register writes to the config register file
module config_cmd_decoder
    import config_cmd_decoder_pkg::*;
#(
    parameter logic [7:0]  HDR0        = HDR0_DEFAULT,
    parameter logic [7:0]  HDR1        = HDR1_DEFAULT,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  rx_byte_in,
    input  logic        rx_valid_in,
    output logic        wr_out,
    output logic [7:0]  wr_addr_out,
    output logic [15:0] data_out,
    output logic        busy_out,
    output logic [15:0] frame_ok_cnt_out,
    output logic [15:0] frame_err_cnt_out
);

    state_t      state_q, state_d;
    logic [15:0] idle_q, idle_d;
    logic [7:0]  addr_sh_q, dhi_sh_q, dlo_sh_q;
    logic        cap_addr, cap_dhi, cap_dlo;
    logic        wr_d, ok_inc, err_inc;
    logic        wr_q;
    logic [7:0]  wr_addr_q;
    logic [15:0] data_q;
    logic        frame_good;

    always_comb begin
        state_d    = state_q;
        idle_d     = idle_q;
        cap_addr   = 1'b0;
        cap_dhi    = 1'b0;
        cap_dlo    = 1'b0;
        wr_d       = 1'b0;
        ok_inc     = 1'b0;
        err_inc    = 1'b0;
        frame_good = (rx_byte_in == cks_of(addr_sh_q, dhi_sh_q, dlo_sh_q)) && addr_in_range(addr_sh_q);

        if (rx_valid_in) begin
            // A byte always wins over a timeout landing on the same cycle.
            idle_d = 16'd0;
            case (state_q)
                ST_IDLE: if (rx_byte_in == HDR0) state_d = ST_SYNC;
                ST_SYNC: begin
                    if (rx_byte_in == HDR1) begin
                        state_d = ST_ADDR;
                    end else if (rx_byte_in != HDR0) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    cap_addr = 1'b1;
                    state_d  = ST_DHI;
                end
                ST_DHI: begin
                    cap_dhi = 1'b1;
                    state_d = ST_DLO;
                end
                ST_DLO: begin
                    cap_dlo = 1'b1;
                    state_d = ST_CKS;
                end
                ST_CKS: begin
                    state_d = ST_IDLE;
                    if (frame_good) begin
                        wr_d   = 1'b1;
                        ok_inc = 1'b1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (idle_q == TIMEOUT_CYC - 16'd1) begin
                state_d = ST_IDLE;
                idle_d  = 16'd0;
                err_inc = 1'b1;
            end else begin
                idle_d = idle_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            idle_q    <= 16'd0;
            addr_sh_q <= 8'h00;
            dhi_sh_q  <= 8'h00;
            dlo_sh_q  <= 8'h00;
            wr_q      <= 1'b0;
            wr_addr_q <= WR_ADDR_RST;
            data_q    <= DATA_RST;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wr_q    <= wr_d;
            if (cap_addr) addr_sh_q <= rx_byte_in;
            if (cap_dhi)  dhi_sh_q  <= rx_byte_in;
            if (cap_dlo)  dlo_sh_q  <= rx_byte_in;
            // Write outputs only move when a good frame completes.
            if (wr_d) begin
                wr_addr_q <= addr_sh_q;
                data_q    <= {dhi_sh_q, dlo_sh_q};
            end
        end
    end

    assign wr_out      = wr_q;
    assign wr_addr_out = wr_addr_q;
    assign data_out    = data_q;
    assign busy_out    = (state_q != ST_IDLE);

    sat_cnt16 u_ok_cnt (
        .clk_in    (clk_in),
        .clr_in    (rst_in),
        .inc_in    (ok_inc),
        .count_out (frame_ok_cnt_out)
    );

    sat_cnt16 u_err_cnt (
        .clk_in    (clk_in),
        .clr_in    (rst_in),
        .inc_in    (err_inc),
        .count_out (frame_err_cnt_out)
    );

endmodule
